// File: rtl/dump_pkg.sv
// -----------------------------------------------------------------------------
// dump_pkg: definitions shared by the register-file dump transmitter and
// by the debug command FSM, which imports it to decode the dump state.
//   dump_state_e   : dump FSM state encoding
//   DEF_*          : default widths of the dump path
//   BYTES_PER_WORD : bytes sent per register word (default widths)
//   BCNT_W         : byte-counter width (default widths)
//   bcnt_width()   : byte-counter width for any bytes-per-word value
// Optional feature macro used by the dump block: REGFILE_DUMP_CHECKSUM_EN.
// -----------------------------------------------------------------------------
package dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_CKSUM = 3'd3,
    ST_DONE  = 3'd4
  } dump_state_e;

  localparam int DEF_NB         = 32;
  localparam int DEF_BYTE_NB    = 8;
  localparam int BYTES_PER_WORD = DEF_NB / DEF_BYTE_NB;

  // A one-byte word still needs a 1-bit counter to stay a legal vector.
  function automatic int bcnt_width(input int bpw);
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

  localparam int BCNT_W = bcnt_width(BYTES_PER_WORD);

endpackage

// File: rtl/regfile_dump_tx_serializer.sv
// -----------------------------------------------------------------------------
// word_byte_serializer: holds one register word and presents it as bytes,
// MSB first, under a valid/ready handshake.
//   i_clk, i_reset : clock, asynchronous active-low reset
//   i_load         : capture i_word and restart the byte count
//   i_word         : word to serialise
//   i_active       : parent is offering bytes (drives valid)
//   i_ready        : consumer accepts the offered byte this cycle
//   o_byte         : byte currently offered (upper BYTE_NB bits)
//   o_accept       : handshake completes at the coming edge
//   o_last_byte    : the offered byte is the final one of the word
// -----------------------------------------------------------------------------
module word_byte_serializer
  import dump_pkg::*;
#(
  parameter int NB      = 32,
  parameter int BYTE_NB = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB-1:0]      i_word,
  input  logic               i_active,
  input  logic               i_ready,
  output logic [BYTE_NB-1:0] o_byte,
  output logic               o_accept,
  output logic               o_last_byte
);

  localparam int BPW = NB / BYTE_NB;
  localparam int CW  = bcnt_width(BPW);

  logic [NB-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Valid/ready: a byte transfers on a rising edge where valid (i_active)
  // and ready are both high; the offered byte is held until then.
  assign o_accept    = i_active & i_ready;
  assign o_byte      = shift_q[NB-1 -: BYTE_NB];
  assign o_last_byte = (cnt_q == CW'(BPW - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (i_load) begin
      shift_d = i_word;
      cnt_d   = '0;
    end else if (o_accept) begin
      shift_d = shift_q << BYTE_NB;
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_dump_tx.sv
// -----------------------------------------------------------------------------
// regfile_dump_tx: on i_start, reads registers 0..NUM_REGS-1 through the
// register-file debug port and streams each word MSB-first to the UART TX.
//   i_clk, i_reset          : clock, asynchronous active-low reset
//   i_start                 : dump request, honoured only in IDLE
//   i_mips_register_data    : combinational read data for the address out
//   i_tx_ready              : UART TX accepts a byte this cycle
//   o_mips_register_number  : register being read (registered)
//   o_tx_data, o_tx_valid   : byte offered to the TX and its valid
//   o_busy                  : dump in progress (LATCH..DONE)
//   o_done                  : one-cycle pulse at completion
//   o_state                 : current FSM state for debug visibility
// Macro REGFILE_DUMP_CHECKSUM_EN appends an XOR checksum byte after the data.
// -----------------------------------------------------------------------------
module regfile_dump_tx
  import dump_pkg::*;
#(
  parameter int NB       = 32,
  parameter int REGS     = 5,
  parameter int NUM_REGS = 32,
  parameter int BYTE_NB  = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB-1:0]      i_mips_register_data,
  input  logic               i_tx_ready,
  output logic [REGS-1:0]    o_mips_register_number,
  output logic [BYTE_NB-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_busy,
  output logic               o_done,
  output dump_state_e        o_state
);

  localparam logic [REGS-1:0] LAST_IDX = REGS'(NUM_REGS - 1);

  dump_state_e        state_q;
  logic [REGS-1:0]    idx_q;
  logic [BYTE_NB-1:0] ser_byte;
  logic               ser_accept;
  logic               ser_last;

  word_byte_serializer #(
    .NB      (NB),
    .BYTE_NB (BYTE_NB)
  ) u_ser (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (state_q == ST_LATCH),
    .i_word      (i_mips_register_data),
    .i_active    (state_q == ST_SEND),
    .i_ready     (i_tx_ready),
    .o_byte      (ser_byte),
    .o_accept    (ser_accept),
    .o_last_byte (ser_last)
  );

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [BYTE_NB-1:0] cksum_q;
`endif

  // All outputs decode the state flop directly, so they fall with reset
  // without waiting for a clock edge.
  assign o_mips_register_number = idx_q;
  assign o_busy  = (state_q != ST_IDLE);
  assign o_done  = (state_q == ST_DONE);
  assign o_state = state_q;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  assign o_tx_valid = (state_q == ST_SEND) || (state_q == ST_CKSUM);
  assign o_tx_data  = (state_q == ST_SEND)  ? ser_byte :
                      (state_q == ST_CKSUM) ? cksum_q  : '0;
`else
  assign o_tx_valid = (state_q == ST_SEND);
  assign o_tx_data  = (state_q == ST_SEND) ? ser_byte : '0;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      cksum_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            idx_q   <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            cksum_q <= '0;
`endif
            state_q <= ST_LATCH;
          end
        end
        ST_LATCH: state_q <= ST_SEND;
        ST_SEND: begin
          if (ser_accept) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            cksum_q <= cksum_q ^ ser_byte;
`endif
            if (ser_last) begin
              if (idx_q != LAST_IDX) begin
                idx_q   <= idx_q + REGS'(1);
                state_q <= ST_LATCH;
              end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                state_q <= ST_CKSUM;
`else
                state_q <= ST_DONE;
`endif
              end
            end
          end
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        ST_CKSUM: if (i_tx_ready) state_q <= ST_DONE;
`endif
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_tx.sv
module tb_regfile_dump_tx;
  import dump_pkg::*;

  // ---------------- clock / reset ----------------
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_tx_ready = 1'b1;
  logic [31:0] i_mips_register_data;
  logic [4:0]  o_mips_register_number;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        o_busy;
  logic        o_done;
  dump_state_e o_state;

  always #5 i_clk = ~i_clk;

  regfile_dump_tx dut (
    .i_clk                  (i_clk),
    .i_reset                (i_reset),
    .i_start                (i_start),
    .i_mips_register_data   (i_mips_register_data),
    .i_tx_ready             (i_tx_ready),
    .o_mips_register_number (o_mips_register_number),
    .o_tx_data              (o_tx_data),
    .o_tx_valid             (o_tx_valid),
    .o_busy                 (o_busy),
    .o_done                 (o_done),
    .o_state                (o_state)
  );

  // Register-file model answering the debug read port.
  logic [31:0] rf [32];
  assign i_mips_register_data = rf[o_mips_register_number];

  // ---------------- monitor ----------------
  // Inputs change just after the rising edge, so at the falling edge a high
  // valid and ready means that byte transfers at the next rising edge.
  logic [7:0] got_q[$];
  int         done_cnt = 0;

  always @(negedge i_clk) begin
    if (i_reset && o_tx_valid && i_tx_ready) got_q.push_back(o_tx_data);
    if (o_done) done_cnt++;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_dump(input string tag);
    logic [7:0] exp_q[$];
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < 32; k++)
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(rf[k][8*b +: 8]);
        x = x ^ rf[k][8*b +: 8];
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'h0, got_q[i]}, {24'h0, exp_q[i]});
    chk({tag, "_done_once"}, done_cnt, 1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_dump();
    got_q.delete();
    done_cnt = 0;
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    for (t = 0; t < 2000 && done_cnt == 0; t++) cyc();
    cyc();
    chk({tag, "_no_timeout"}, (done_cnt > 0), 1);
  endtask

  task automatic wait_reg(input string tag, input logic [4:0] r);
    int t;
    for (t = 0; t < 2000 && !(o_mips_register_number == r && o_tx_valid); t++) cyc();
    chk({tag, "_reach_reg"}, o_mips_register_number, {27'h0, r});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int first_v;
    int done_at;
    int t;

    for (int k = 0; k < 32; k++) rf[k] = k * 32'h01010101;

    // Reset state
    #12;
    chk("rst_valid", o_tx_valid, 0);
    chk("rst_busy",  o_busy, 0);
    chk("rst_done",  o_done, 0);
    chk("rst_regnum", o_mips_register_number, 0);
    chk("rst_data",  o_tx_data, 0);
    chk("rst_state", o_state, ST_IDLE);
    cyc();
    i_reset = 1'b1;
    cyc();
    cyc();

    // Full dump with ready high: timing and contents
    start_dump();
    chk("busy_after_start", o_busy, 1);
    first_v = 0;
    done_at = 0;
    // Start edge was the last rising edge: cycle n after it is at negedge n
    // counting from the cycle just entered.
    for (int n = 1; n <= 170; n++) begin
      if (n > 1) @(posedge i_clk);
      @(negedge i_clk);
      if (o_tx_valid && first_v == 0) first_v = n;
      if (o_done && done_at == 0) done_at = n;
    end
    cyc();
    chk("first_valid_cycle", first_v, 2);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    chk("done_cycle", done_at, 162);
`else
    chk("done_cycle", done_at, 161);
`endif
    compare_dump("full");
    chk("idle_after_dump", o_busy, 0);

    // Backpressure on byte 2 of register 5
    rf[5] = 32'h11223344;
    start_dump();
    for (t = 0; t < 2000 && got_q.size() < 22; t++) cyc();
    i_tx_ready = 1'b0;
    for (int s = 0; s < 10; s++) begin
      cyc();
      chk("stall_valid", o_tx_valid, 1);
      chk("stall_data", o_tx_data, 32'h33);
      chk("stall_no_accept", got_q.size(), 22);
    end
    i_tx_ready = 1'b1;
    wait_done("bp");
    chk("bp_byte22", got_q[22], 32'h33);
    chk("bp_byte23", got_q[23], 32'h44);
    compare_dump("bp");

    // Start pulse while busy is ignored
    start_dump();
    wait_reg("busy_start", 5'd10);
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    wait_done("busy_start");
    cyc();
    cyc();
    compare_dump("busy_start");
    chk("busy_start_idle", o_state, ST_IDLE);

    // Asynchronous reset mid-dump, then restart from register 0
    rf[0] = 32'hA5B6C7D8;
    start_dump();
    wait_reg("mid_rst", 5'd20);
    #2;
    i_reset = 1'b0;
    #1;
    chk("mid_rst_valid", o_tx_valid, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_done", o_done, 0);
    chk("mid_rst_regnum", o_mips_register_number, 0);
    cyc();
    cyc();
    i_reset = 1'b1;
    cyc();
    start_dump();
    wait_done("restart");
    chk("restart_first_byte", got_q[0], 32'hA5);
    compare_dump("restart");

`ifdef REGFILE_DUMP_CHECKSUM_EN
    // Checksum: only register 1 non-zero
    for (int k = 0; k < 32; k++) rf[k] = 32'h0;
    rf[1] = 32'h000000FF;
    start_dump();
    wait_done("cksum");
    chk("cksum_count", got_q.size(), 129);
    chk("cksum_last", got_q[128], 32'hFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_dump_tx.md
Name: regfile_dump_tx

Overview:
- Debug-side reader of the decode stage's register-file debug port.
- On a start pulse, walks register numbers 0..NUM_REGS-1 and drives each onto the debug read-address output. It captures the returned word and streams it as bytes, MSB first, into the debug UART transmitter over a valid/ready handshake.
- Sits between the debug unit's command FSM and the UART TX. Pipeline is halted (i_step low) by the debug unit for the whole dump.

Parameters:
- NB, 32, register data width in bits; must be a multiple of BYTE_NB.
- REGS, 5, register-number width.
- NUM_REGS, 32, number of registers dumped; must be ≤ 2**REGS.
- BYTE_NB, 8, width of one transmitted byte.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- i_mips_register_data  in  NB  combinational read data for o_mips_register_number.
- i_tx_ready  in  1  UART TX can accept a byte this cycle.
- o_mips_register_number  out  REGS  register number being read; registered.
- o_tx_data  out  BYTE_NB  byte offered to the TX.
- o_tx_valid  out  1  o_tx_data is valid.
- o_busy  out  1  high from the cycle after start acceptance until DONE exits.
- o_done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (asynchronous on i_reset low):
  - state=IDLE.
  - o_mips_register_number=0, o_tx_data=0.
  - o_tx_valid, o_busy and o_done are 0.
  - Index, byte counter and shift register are cleared.
  - Reset mid-dump aborts immediately and drops o_tx_valid. The next i_start restarts at register 0.
- IDLE: if i_start=1, set idx=0 and o_mips_register_number=0, then go to LATCH.
- LATCH (1 cycle):
  - Load the shift register with i_mips_register_data.
  - Clear byte_cnt and go to SEND.
- SEND:
  - o_tx_valid=1 and o_tx_data = shift register upper BYTE_NB bits.
  - A byte is accepted when o_tx_valid and i_tx_ready are both 1 at the clock edge.
  - On acceptance, shift left by BYTE_NB and increment byte_cnt.
  - After byte NB/BYTE_NB-1 is accepted:
    - if idx < NUM_REGS-1, increment idx and o_mips_register_number, then go to LATCH;
    - otherwise go to DONE (or CKSUM when enabled).
- Stall: while i_tx_ready=0, o_tx_valid stays 1 and o_tx_data stays stable. There is no timeout.
- DONE (1 cycle): o_done=1, o_busy=1, o_tx_valid=0, then go to IDLE.
- Timing with i_tx_ready held high: the first o_tx_valid comes 2 cycles after the start edge. Each register costs 5 cycles. o_done is high in cycle 161 after the start edge when NUM_REGS=32.
- i_start while busy is ignored, not queued.
- o_tx_valid is never high outside SEND/CKSUM.
- Data is captured once per register in LATCH. Later changes on i_mips_register_data do not affect bytes already latched.

Optional Feature:
- Macro: REGFILE_DUMP_CHECKSUM_EN.
- Defined: a running XOR of every accepted data byte (cleared at start) is sent as one extra byte in state CKSUM, under the same handshake, before DONE. Total byte count is NUM_REGS*NB/BYTE_NB+1.
- Undefined: no checksum register or state. The last data byte goes straight to DONE.

Decomposition:
- Shared package dump_pkg holds:
  - state encoding (IDLE, LATCH, SEND, CKSUM, DONE);
  - BYTES_PER_WORD = NB/BYTE_NB;
  - byte-counter width.
- The debug command FSM imports it for state visibility.
- One natural sub-module, word_byte_serializer: load/shift register, byte counter, and valid/ready handling, with a last_byte output to the parent FSM.

Test Plan:
- Reset: hold i_reset=0 mid-SEND -> o_tx_valid=0, o_busy=0, o_done=0, o_mips_register_number=0 immediately, without waiting for a clock edge.
- Full dump: register k = k*32'h01010101, i_tx_ready=1 -> 128 bytes, where byte 4k..4k+3 all equal k. o_done is high exactly in cycle 161 after the start edge, and o_done asserts exactly once.
- Backpressure: i_tx_ready=0 for 10 cycles while offering byte 2 of reg 5 (value 32'h11223344) -> o_tx_data=8'h33 held stable with o_tx_valid=1. The next accepted byte is 8'h44, with no duplication or loss.
- Start while busy: pulse i_start during reg 10 -> dump continues unchanged, exactly 128 bytes, and one o_done.
- Reset mid-dump at reg 20, release, then pulse i_start -> the first accepted byte is the MSB of reg 0.
- With REGFILE_DUMP_CHECKSUM_EN: reg1=32'h000000FF, all other registers 0 -> 129 bytes, and the final byte is 8'hFF.
